msft_dv_tb_reset_seq_checker: RTL and testbench



---
 rtl/msft_reset_chk_pkg.sv | 35 +++
 rtl/msft_dv_tb_reset_seq_checker.sv | 123 ++++++++++++
 tb/tb_msft_dv_tb_reset_seq_checker.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msft_reset_chk_pkg.sv
// Shared types for the reset/boot sequence checker: stage and error-code
// enums, plus the thermometer-code helper used to build legal progress vectors.
package msft_reset_chk_pkg;

    // Number of sequence signals folded into the progress vector.
    localparam int NUM_SIG = 5;

    typedef enum logic [2:0] {
        ST_POR    = 3'd0,  // nothing released yet
        ST_PRST   = 3'd1,  // power-on reset released
        ST_CLK    = 3'd2,  // clock started
        ST_SRST   = 3'd3,  // system reset released
        ST_REPAIR = 3'd4,  // memory repair done
        ST_RUN    = 3'd5   // run-stall released, sequence complete
    } stage_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ORDER   = 3'd1,  // out-of-order, skip or non-thermometer code
        ERR_EARLY   = 3'd2,  // advance closer than MIN_GAP to the previous one
        ERR_TIMEOUT = 3'd3,  // no advance within MAX_GAP cycles
        ERR_REGRESS = 3'd4   // an already-reached stage was withdrawn
    } err_code_e;

    // Thermometer code with bits 0..k-1 set; k saturates at NUM_SIG.
    function automatic logic [NUM_SIG-1:0] T(input int k);
        logic [NUM_SIG-1:0] code;
        code = '0;
        for (int i = 0; i < NUM_SIG; i++) begin
            if (i < k) code[i] = 1'b1;
        end
        return code;
    endfunction

endpackage

// File: rtl/msft_dv_tb_reset_seq_checker.sv
// Reset/boot sequence checker. Tracks the ordered stages POR release, clock
// start, system reset release, memory repair done and run-stall release,
// enforcing a minimum spacing between advances and latching the first error.
// Optional feature: define MSFT_RESET_CHK_TIMEOUT_EN to flag a stage that
// stalls for MAX_GAP cycles before the sequence completes.
module msft_dv_tb_reset_seq_checker
    import msft_reset_chk_pkg::*;
#(
    parameter int MIN_GAP = 16,
    parameter int MAX_GAP = 1024,
    localparam int GW = $clog2(MAX_GAP + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          prstn_i,
    input  logic          start_clk_i,
    input  logic          srstn_i,
    input  logic          mem_repair_done_i,
    input  logic          run_stall_i,
    output logic [2:0]    stage_o,
    output logic          seq_done_o,
    output logic          seq_err_o,
    output logic [2:0]    err_code_o,
    output logic [2:0]    err_stage_o,
    output logic [GW-1:0] last_gap_o
);

    localparam logic [GW-1:0] GAP_SAT = '1;
    localparam logic [GW:0]   MIN_W   = (GW+1)'(MIN_GAP);
`ifdef MSFT_RESET_CHK_TIMEOUT_EN
    localparam logic [GW:0]   MAX_W   = (GW+1)'(MAX_GAP);
`endif

    stage_e        stage_q;
    err_code_e     err_code_q;
    logic [2:0]    err_stage_q;
    logic          err_q;
    logic          done_q;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] last_gap_q;

    logic [NUM_SIG-1:0] v;
    logic [NUM_SIG-1:0] t_cur;
    logic [NUM_SIG-1:0] t_nxt;
    logic [GW:0]        gap_inc_w;  // gap + 1 without saturation
    logic [GW-1:0]      gap_inc;    // gap + 1 saturated to the counter width
    logic               adv;
    logic               err_take;
    err_code_e          err_kind;

    assign v         = {~run_stall_i, mem_repair_done_i, srstn_i, start_clk_i, prstn_i};
    assign t_cur     = T(int'(stage_q));
    assign t_nxt     = T(int'(stage_q) + 1);
    assign gap_inc_w = {1'b0, gap_q} + 1'b1;
    assign gap_inc   = gap_inc_w[GW] ? GAP_SAT : gap_inc_w[GW-1:0];

    // Classify this cycle's progress vector against the current stage.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the if/else chain can leave a latch behind.
        adv      = 1'b0;
        err_take = 1'b0;
        err_kind = ERR_NONE;
        if (v == t_cur) begin
`ifdef MSFT_RESET_CHK_TIMEOUT_EN
            if (stage_q != ST_RUN && gap_inc_w == MAX_W) begin
                err_take = 1'b1;
                err_kind = ERR_TIMEOUT;
            end
`endif
        end else if (stage_q != ST_RUN && v == t_nxt) begin
            if (gap_inc_w < MIN_W) begin
                err_take = 1'b1;
                err_kind = ERR_EARLY;
            end else begin
                adv = 1'b1;
            end
        end else if ((v & t_cur) != t_cur) begin
            err_take = 1'b1;
            err_kind = ERR_REGRESS;
        end else begin
            err_take = 1'b1;
            err_kind = ERR_ORDER;
        end
    end

    // Stage tracker: advance, hold or latch the first error; frozen once in error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst_i) begin
            stage_q     <= ST_POR;
            err_code_q  <= ERR_NONE;
            err_stage_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            gap_q       <= '0;
            last_gap_q  <= '0;
        end else if (!err_q) begin
            if (err_take) begin
                err_q       <= 1'b1;
                err_code_q  <= err_kind;
                err_stage_q <= stage_q;
                done_q      <= 1'b0;
            end else if (adv) begin
                stage_q    <= stage_e'(stage_q + 3'd1);
                last_gap_q <= gap_inc;
                gap_q      <= '0;
                done_q     <= (stage_q == ST_REPAIR);
            end else begin
                gap_q <= gap_inc;
            end
        end
    end

    assign stage_o     = stage_q;
    assign seq_done_o  = done_q;
    assign seq_err_o   = err_q;
    assign err_code_o  = err_code_q;
    assign err_stage_o = err_stage_q;
    assign last_gap_o  = last_gap_q;

endmodule

// File: tb/tb_msft_dv_tb_reset_seq_checker.sv
// Bench for msft_dv_tb_reset_seq_checker. A behavioural model tracks the
// sequence with plain integer arithmetic; tasks drive directed and random
// scenarios and compare the checker's outputs against the model and against
// fixed expectations. Follows MSFT_RESET_CHK_TIMEOUT_EN like the design.
module tb_msft_dv_tb_reset_seq_checker;

    localparam int MIN_GAP = 16;
    localparam int MAX_GAP = 1024;
    localparam int GW      = $clog2(MAX_GAP + 1);
    localparam int GAP_SAT = (1 << GW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prstn = 1'b0;
    logic          start_clk = 1'b0;
    logic          srstn = 1'b0;
    logic          mem_repair_done = 1'b0;
    logic          run_stall = 1'b1;
    logic [2:0]    stage;
    logic          seq_done;
    logic          seq_err;
    logic [2:0]    err_code;
    logic [2:0]    err_stage;
    logic [GW-1:0] last_gap;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    int m_stage;
    int m_gap;
    int m_last;
    bit m_err;
    int m_code;
    int m_estage;

    msft_dv_tb_reset_seq_checker #(.MIN_GAP(MIN_GAP), .MAX_GAP(MAX_GAP)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .prstn_i           (prstn),
        .start_clk_i       (start_clk),
        .srstn_i           (srstn),
        .mem_repair_done_i (mem_repair_done),
        .run_stall_i       (run_stall),
        .stage_o           (stage),
        .seq_done_o        (seq_done),
        .seq_err_o         (seq_err),
        .err_code_o        (err_code),
        .err_stage_o       (err_stage),
        .last_gap_o        (last_gap)
    );

    always #5 clk = ~clk;

    // Observed outputs packed as {stage, done, err, code, err_stage, last_gap}.
    wire [10+GW:0] dut_vec = {stage, seq_done, seq_err, err_code, err_stage, last_gap};

    function automatic logic [4:0] tv(input int k);
        return 5'((1 << k) - 1);
    endfunction

    function automatic logic [10+GW:0] model_vec();
        return {3'(m_stage), 1'(m_stage == 5 && !m_err), 1'(m_err),
                3'(m_code), 3'(m_estage), GW'(m_last)};
    endfunction

    function automatic void model_reset();
        m_stage = 0; m_gap = 0; m_last = 0;
        m_err = 1'b0; m_code = 0; m_estage = 0;
    endfunction

    function automatic void take_err(input int code);
        m_err = 1'b1; m_code = code; m_estage = m_stage;
    endfunction

    // One sampling edge of the sequence rules, expressed on integers.
    function automatic void model_eval();
        int  v, need, j;
        bit  therm;
        v = int'({~run_stall, mem_repair_done, srstn, start_clk, prstn});
        if (m_err) return;
        therm = ((v & (v + 1)) == 0);
        j     = $countones(v);
        need  = (1 << m_stage) - 1;
        if (therm && j == m_stage) begin
`ifdef MSFT_RESET_CHK_TIMEOUT_EN
            if (m_stage < 5 && m_gap + 1 == MAX_GAP) begin
                take_err(3);
                return;
            end
`endif
            m_gap = (m_gap + 1 > GAP_SAT) ? GAP_SAT : m_gap + 1;
        end else if (therm && j == m_stage + 1) begin
            if (m_gap + 1 < MIN_GAP) take_err(2);
            else begin
                m_stage = m_stage + 1;
                m_last  = (m_gap + 1 > GAP_SAT) ? GAP_SAT : m_gap + 1;
                m_gap   = 0;
            end
        end else if ((v & need) != need) begin
            take_err(4);
        end else begin
            take_err(1);
        end
    endfunction

    task automatic drive_v(input logic [4:0] v);
        prstn = v[0]; start_clk = v[1]; srstn = v[2];
        mem_repair_done = v[3]; run_stall = ~v[4];
    endtask

    // Advance n clock edges, updating the model at each, ending 1 ns after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_eval();
            #1;
        end
    endtask

    // Asynchronous reset pulse between edges; leaves inputs at T(0).
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        drive_v(tv(0));
        #3;
        rst = 1'b0;
    endtask

    // From a fresh reset, advance to stage n with the given spacing.
    task automatic run_to(input int n, input int spacing);
        for (int k = 1; k <= n; k++) begin
            step(spacing - 1);
            drive_v(tv(k));
            step(1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_v(5'h1f);
        #12;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", dut_vec);
        end
        do_reset();
        step(3);
        checks++;
        if (dut_vec !== model_vec() || stage !== 3'd0) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_nominal();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(99);
            drive_v(tv(k));
            step(1);
            checks++;
            if (stage !== 3'(k) || last_gap !== GW'(100) || err_code !== 3'd0
                || dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL nominal_stage%0d: got %h want %h", k, dut_vec, model_vec());
            end
        end
        step(5);
        checks++;
        if (seq_done !== 1'b1 || seq_err !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done: got done=%b err=%b want done=1 err=0", seq_done, seq_err);
        end
    endtask

    task automatic test_min_spacing();
        do_reset();
        run_to(2, 20);
        step(14);
        drive_v(tv(3));
        step(1);
        checks++;
        if (err_code !== 3'd2 || err_stage !== 3'd2 || stage !== 3'd2
            || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL early_15: got %h want code=2 estage=2 stage=2", dut_vec);
        end
        do_reset();
        run_to(2, 20);
        step(15);
        drive_v(tv(3));
        step(1);
        checks++;
        if (stage !== 3'd3 || seq_err !== 1'b0 || last_gap !== GW'(16)
            || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL exact_16: got %h want stage=3 gap=16 no error", dut_vec);
        end
    endtask

    task automatic test_skip();
        do_reset();
        run_to(2, 20);
        step(10);
        drive_v(tv(2) | 5'b01000);
        step(1);
        checks++;
        if (err_code !== 3'd1 || err_stage !== 3'd2 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL skip_repair: got %h want code=1 estage=2", dut_vec);
        end
        do_reset();
        step(20);
        drive_v(tv(2));
        step(1);
        checks++;
        if (err_code !== 3'd1 || err_stage !== 3'd0 || stage !== 3'd0
            || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL double_step: got %h want code=1 estage=0", dut_vec);
        end
    endtask

    task automatic test_regression();
        do_reset();
        run_to(5, 20);
        step(4);
        drive_v(tv(4));
        step(1);
        checks++;
        if (err_code !== 3'd4 || err_stage !== 3'd5 || seq_done !== 1'b0
            || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL regress_run: got %h want code=4 estage=5 done=0", dut_vec);
        end
        drive_v(tv(5));
        step(3);
        checks++;
        if (err_code !== 3'd4 || seq_err !== 1'b1) begin
            errors++;
            $display("FAIL regress_sticky: got code=%0d err=%b want code=4 err=1", err_code, seq_err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_to(3, 20);
        step(MAX_GAP - 1);
        checks++;
        if (seq_err !== 1'b0 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL timeout_pre: got %h want no error", dut_vec);
        end
        step(1);
        checks++;
`ifdef MSFT_RESET_CHK_TIMEOUT_EN
        if (err_code !== 3'd3 || err_stage !== 3'd3 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL timeout_hit: got %h want code=3 estage=3", dut_vec);
        end
`else
        if (seq_err !== 1'b0 || stage !== 3'd3 || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL timeout_off: got %h want stage=3 no error", dut_vec);
        end
`endif
        step(100);
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL timeout_after: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_to(3, 30);
        step(7);
        rst = 1'b1;
        #2;
        checks++;
        if (dut_vec !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %h want 0", dut_vec);
        end
        model_reset();
        drive_v(tv(0));
        #3;
        rst = 1'b0;
        run_to(5, 40);
        step(2);
        checks++;
        if (stage !== 3'd5 || seq_done !== 1'b1 || seq_err !== 1'b0
            || last_gap !== GW'(40) || dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL reset_replay: got %h want %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        int gap;
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int k = 1; k <= 5 && !m_err; k++) begin
                gap = int'($urandom_range(10, 30));
                for (int c = 1; c <= gap && !m_err; c++) begin
                    if ($urandom_range(0, 24) == 0) drive_v(5'($urandom_range(0, 31)));
                    else drive_v(c == gap ? tv(k) : tv(k - 1));
                    step(1);
                    checks++;
                    if (dut_vec !== model_vec()) begin
                        errors++;
                        $display("FAIL random_r%0d_k%0d: got %h want %h", r, k, dut_vec, model_vec());
                    end
                end
            end
            step(3);
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL random_end_r%0d: got %h want %h", r, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_nominal();
        test_min_spacing();
        test_skip();
        test_regression();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
